// File: rtl/timer_seq_pkg.sv
// rtl/timer_seq_pkg.sv - register map, control bits and state encoding for timer_sequencer
package timer_seq_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CTRL     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTRL,
        S_RUN,
        S_CLR_ST,
        S_WR_STOP,
        S_SNAP_WR,
        S_SNAP_RL,
        S_SNAP_RH,
        S_SNAP_DONE
    } state_t;

    function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                              input logic cont, input logic ito);
        logic [15:0] w;
        w             = '0;
        w[CTRL_STOP]  = stop;
        w[CTRL_START] = start;
        w[CTRL_CONT]  = cont;
        w[CTRL_ITO]   = ito;
        return w;
    endfunction

endpackage

// File: rtl/timer_sequencer.sv
// rtl/timer_sequencer.sv - sequences configuration, interrupt service, stop and snapshot for a bus timer
module timer_sequencer
    import timer_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [31:0]      cfg_period,
    input  logic             cfg_continuous,
    input  logic             stop_req,
    input  logic             snap_req,
    output logic             snap_valid,
    output logic [31:0]      snap_value,
    output logic             timeout_pulse,
    output logic [CNT_W-1:0] timeout_count,
    output logic             busy,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic [15:0]      tmr_readdata,
    input  logic             tmr_irq
);

    state_t      state, state_nxt;
    logic [31:0] period_q;
    logic        cont_q;
    logic        stop_pend, snap_pend;
    logic        snap_ret_run;
    logic [15:0] snap_lo;
    logic [31:0] snap_q;

    logic        in_idle, in_run;
    logic        stop_eff, snap_eff;
    logic        cfg_acc;
    logic        stop_start, snap_start;

    assign in_idle  = (state == S_IDLE);
    assign in_run   = (state == S_RUN);
    assign stop_eff = stop_req | stop_pend;
    assign snap_eff = snap_req | snap_pend;

    // In RUN a pending interrupt or stop outranks a new configuration, so refuse it up front.
    assign cfg_ready = reset_n & (in_idle | (in_run & ~tmr_irq & ~stop_eff));
    assign cfg_acc   = cfg_valid & cfg_ready;

    assign stop_start = in_run & (state_nxt == S_WR_STOP);
    assign snap_start = (in_idle | in_run) & (state_nxt == S_SNAP_WR);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cfg_acc)       state_nxt = S_WR_PL;
                else if (snap_eff) state_nxt = S_SNAP_WR;
            end
            S_RUN: begin
                if (tmr_irq)       state_nxt = S_CLR_ST;
                else if (stop_eff) state_nxt = S_WR_STOP;
                else if (cfg_acc)  state_nxt = S_WR_PL;
                else if (snap_eff) state_nxt = S_SNAP_WR;
            end
            S_WR_PL:     state_nxt = S_WR_PH;
            S_WR_PH:     state_nxt = S_WR_CTRL;
            S_WR_CTRL:   state_nxt = S_RUN;
            S_CLR_ST:    state_nxt = cont_q ? S_RUN : S_IDLE;
            S_WR_STOP:   state_nxt = S_IDLE;
            S_SNAP_WR:   state_nxt = S_SNAP_RL;
            S_SNAP_RL:   state_nxt = S_SNAP_RH;
            S_SNAP_RH:   state_nxt = S_SNAP_DONE;
            S_SNAP_DONE: state_nxt = snap_ret_run ? S_RUN : S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tmr_address    = '0;
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_writedata  = '0;
        case (state)
            S_WR_PL: begin
                tmr_address    = ADDR_PERIOD_L;
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_writedata  = period_q[15:0];
            end
            S_WR_PH: begin
                tmr_address    = ADDR_PERIOD_H;
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_writedata  = period_q[31:16];
            end
            S_WR_CTRL: begin
                tmr_address    = ADDR_CTRL;
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_writedata  = ctrl_word(1'b0, 1'b1, cont_q, 1'b1);
            end
            S_CLR_ST: begin
                tmr_address    = ADDR_STATUS;
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
            end
            S_WR_STOP: begin
                tmr_address    = ADDR_CTRL;
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_writedata  = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
            end
            S_SNAP_WR: begin
                tmr_address    = ADDR_SNAP_L;
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
            end
            S_SNAP_RL: tmr_address = ADDR_SNAP_L;
            S_SNAP_RH: tmr_address = ADDR_SNAP_H;
            default: ;
        endcase
    end

    assign busy          = ~(in_idle | in_run);
    assign timeout_pulse = (state == S_CLR_ST);
    assign snap_valid    = (state == S_SNAP_DONE);
    // The high half arrives in the same cycle snap_valid is raised, so bypass the holding register.
    assign snap_value    = (state == S_SNAP_DONE) ? {tmr_readdata, snap_lo} : snap_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            period_q      <= '0;
            cont_q        <= 1'b0;
            stop_pend     <= 1'b0;
            snap_pend     <= 1'b0;
            snap_ret_run  <= 1'b0;
            snap_lo       <= '0;
            snap_q        <= '0;
            timeout_count <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_acc) begin
                period_q <= cfg_period;
                cont_q   <= cfg_continuous;
            end
            // A stop seen in IDLE has nothing to stop; otherwise hold it until RUN can act on it.
            if (in_idle || stop_start)
                stop_pend <= 1'b0;
            else if (stop_req)
                stop_pend <= 1'b1;
            if (snap_start)
                snap_pend <= 1'b0;
            else if (snap_req)
                snap_pend <= 1'b1;
            if (snap_start)
                snap_ret_run <= in_run;
            if (state == S_SNAP_RH)
                snap_lo <= tmr_readdata;
            if (state == S_SNAP_DONE)
                snap_q <= {tmr_readdata, snap_lo};
            if (in_run && tmr_irq)
                timeout_count <= timeout_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// tb/tb_timer_sequencer.sv - scoreboard bench for timer_sequencer against a behavioural timer
module tb_timer_sequencer;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [31:0]      cfg_period;
    logic             cfg_continuous;
    logic             stop_req;
    logic             snap_req;
    logic             snap_valid;
    logic [31:0]      snap_value;
    logic             timeout_pulse;
    logic [CNT_W-1:0] timeout_count;
    logic             busy;
    logic [2:0]       tmr_address;
    logic             tmr_chipselect;
    logic             tmr_write_n;
    logic [15:0]      tmr_writedata;
    logic [15:0]      tmr_readdata;
    logic             tmr_irq;

    always #5 clk = ~clk;

    timer_sequencer #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .stop_req       (stop_req),
        .snap_req       (snap_req),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
        .timeout_pulse  (timeout_pulse),
        .timeout_count  (timeout_count),
        .busy           (busy),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .tmr_irq        (tmr_irq)
    );

    // Behavioural timer peripheral
    logic [31:0] m_period, m_cnt, m_snap;
    logic        m_run, m_cont, m_irq;
    logic        freeze = 1'b0, load_cnt = 1'b0, force_irq = 1'b0;
    logic [31:0] load_val = '0;

    assign tmr_irq = m_irq | force_irq;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_period     <= '0;
            m_cnt        <= '0;
            m_snap       <= '0;
            m_run        <= 1'b0;
            m_cont       <= 1'b0;
            m_irq        <= 1'b0;
            tmr_readdata <= '0;
        end else begin
            case (tmr_address)
                3'd4:    tmr_readdata <= m_snap[15:0];
                3'd5:    tmr_readdata <= m_snap[31:16];
                default: tmr_readdata <= 16'h0000;
            endcase
            if (load_cnt)
                m_cnt <= load_val;
            else if (m_run && !freeze) begin
                if (m_cnt == m_period) begin
                    m_cnt <= '0;
                    m_irq <= 1'b1;
                    if (!m_cont) m_run <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 32'd1;
                end
            end
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    3'd0: m_irq <= 1'b0;
                    3'd1: begin
                        if (tmr_writedata[2]) begin
                            m_run  <= 1'b1;
                            m_cnt  <= '0;
                            m_cont <= tmr_writedata[1];
                        end
                        if (tmr_writedata[3]) m_run <= 1'b0;
                    end
                    3'd2: begin
                        m_period[15:0] <= tmr_writedata;
                        m_run          <= 1'b0;
                    end
                    3'd3: m_period[31:16] <= tmr_writedata;
                    3'd4, 3'd5: m_snap <= m_cnt;
                    default: ;
                endcase
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0]      q_wr[$];
    logic [CNT_W-1:0] q_tc[$];
    logic [31:0]      q_snap[$];
    logic [CNT_W-1:0] exp_tc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [18:0]      e_wr;
        logic [CNT_W-1:0] e_tc;
        logic [31:0]      e_sn;
        if (reset_n) begin
            if (tmr_chipselect && !tmr_write_n) begin
                if (q_wr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data 0x%04h, no write expected",
                             tmr_address, tmr_writedata);
                end else begin
                    e_wr = q_wr.pop_front();
                    check("bus_write", {13'd0, tmr_address, tmr_writedata}, {13'd0, e_wr});
                end
            end
            if (timeout_pulse) begin
                if (q_tc.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_timeout: count %0d, no timeout expected", timeout_count);
                end else begin
                    e_tc = q_tc.pop_front();
                    check("timeout_count", 32'(timeout_count), 32'(e_tc));
                end
            end
            if (snap_valid) begin
                if (q_snap.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_snap: value 0x%08h, no snapshot expected", snap_value);
                end else begin
                    e_sn = q_snap.pop_front();
                    check("snap_value", snap_value, e_sn);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
        q_wr.push_back({a, d});
    endtask

    task automatic push_cfg(input logic [31:0] p, input logic c);
        push_wr(3'd2, p[15:0]);
        push_wr(3'd3, p[31:16]);
        push_wr(3'd1, c ? 16'h0007 : 16'h0005);
    endtask

    task automatic push_timeout();
        push_wr(3'd0, 16'h0000);
        exp_tc = exp_tc + 1'b1;
        q_tc.push_back(exp_tc);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_cfg(input logic [31:0] p, input logic c);
        cfg_period     = p;
        cfg_continuous = c;
        cfg_valid      = 1'b1;
        @(negedge clk);
        check("cfg_ready_offer", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_cs"},         32'(tmr_chipselect), 32'd0);
        check({tag, "_write_n"},    32'(tmr_write_n),    32'd1);
        check({tag, "_addr_data"},  {13'd0, tmr_address, tmr_writedata}, 32'd0);
        check({tag, "_cfg_ready"},  32'(cfg_ready),      32'd0);
        check({tag, "_busy"},       32'(busy),           32'd0);
        check({tag, "_tcount"},     32'(timeout_count),  32'd0);
        check({tag, "_snap_value"}, snap_value,          32'd0);
        check({tag, "_pulses"},     {30'd0, snap_valid, timeout_pulse}, 32'd0);
    endtask

    initial begin : main
        int lat;
        reset_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_period = '0;
        cfg_continuous = 1'b0;
        stop_req = 1'b0;
        snap_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        reset_n = 1'b1;
        tick();

        // Configuration write burst and stop back to IDLE
        push_cfg(32'h0001_86A0, 1'b1);
        do_cfg(32'h0001_86A0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("cfg_ready_in_burst", 32'(cfg_ready), 32'd0);
            check("busy_in_burst", 32'(busy), 32'd1);
            tick();
        end
        @(negedge clk);
        check("run_busy", 32'(busy), 32'd0);
        check("run_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        push_wr(3'd1, 16'h0008);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        repeat (3) tick();
        check("idle_after_stop_busy", 32'(busy), 32'd0);

        // Stop in IDLE must not touch the bus
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        repeat (5) tick();
        check("stop_idle_cfg_ready", 32'(cfg_ready), 32'd1);

        // One-shot period 49: a single timeout then IDLE
        push_cfg(32'd49, 1'b0);
        push_timeout();
        do_cfg(32'd49, 1'b0);
        repeat (100) tick();
        check("oneshot_busy", 32'(busy), 32'd0);
        check("oneshot_cfg_ready", 32'(cfg_ready), 32'd1);

        // Periodic period 99 over ~1000 cycles: 10 timeouts, counter wraps at 3 bits
        push_cfg(32'd99, 1'b1);
        for (int i = 0; i < 10; i++) push_timeout();
        do_cfg(32'd99, 1'b1);
        repeat (1010) tick();
        check("periodic_tcount", 32'(timeout_count), 32'd3);

        // Reprogram straight from RUN, then snapshot at 0x0002_0010
        push_cfg(32'h0003_0000, 1'b1);
        do_cfg(32'h0003_0000, 1'b1);
        repeat (5) tick();
        freeze   = 1'b1;
        load_cnt = 1'b1;
        load_val = 32'h0002_0010;
        tick();
        load_cnt = 1'b0;
        push_wr(3'd4, 16'h0000);
        q_snap.push_back(32'h0002_0010);
        snap_req = 1'b1;
        @(negedge clk);
        tick();
        snap_req = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (snap_valid) begin
                lat = k;
                break;
            end
        end
        check("snap_latency", 32'(lat), 32'd4);
        repeat (3) tick();
        check("snap_back_in_run", 32'(busy), 32'd0);

        // irq, stop and snap together: CLR_ST, WR_STOP, then snapshot from IDLE
        push_timeout();
        push_wr(3'd1, 16'h0008);
        push_wr(3'd4, 16'h0000);
        q_snap.push_back(32'h0002_0010);
        force_irq = 1'b1;
        stop_req  = 1'b1;
        snap_req  = 1'b1;
        tick();
        force_irq = 1'b0;
        stop_req  = 1'b0;
        snap_req  = 1'b0;
        repeat (15) tick();
        check("triple_end_busy", 32'(busy), 32'd0);
        check("triple_end_tcount", 32'(timeout_count), 32'd4);
        freeze = 1'b0;

        // Reset during WR_PH: no WR_PH/WR_CTRL writes may follow
        push_wr(3'd2, 16'h1234);
        do_cfg(32'h0000_1234, 1'b1);
        tick();
        reset_n = 1'b0;
        #1;
        reset_checks("midreset");
        repeat (3) tick();
        reset_n = 1'b1;
        exp_tc = '0;
        repeat (10) tick();
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_tcount", 32'(timeout_count), 32'd0);

        check("wr_queue_drained", 32'(q_wr.size()), 32'd0);
        check("tc_queue_drained", 32'(q_tc.size()), 32'd0);
        check("snap_queue_drained", 32'(q_snap.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
